// File: rtl/counter_cmd_gen.sv
// counter_cmd_gen: turns raw up/down/clear buttons into en/a_or_m step strobes
// and a shaped rst_counter pulse for one saturating up/down counter.
module counter_cmd_gen #(
    parameter int DB_CYCLES    = 4,
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 4,
    parameter int RST_HOLD     = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_up,
    input  logic btn_dn,
    input  logic btn_clr,
    output logic en,
    output logic a_or_m,
    output logic rst_counter,
    output logic busy
);
    typedef enum logic [2:0] {IDLE, UP_HOLD, DN_HOLD, CLR, GAP} state_t;

    state_t     state, state_n;
    logic [2:0] s1, s2, deb, deb_q, press;
    logic [7:0] db_cnt [3];
    logic [7:0] cnt, cnt_n;
    logic       first, first_n, en_n, dir_n, rc_n, held;

    // Bit 0 = up, bit 1 = down, bit 2 = clear throughout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            deb   <= '0;
            deb_q <= '0;
            press <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            s1    <= {btn_clr, btn_dn, btn_up};
            s2    <= s1;
            deb_q <= deb;
            press <= deb & ~deb_q;
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (tick) begin
                    if (db_cnt[i] == 8'(DB_CYCLES - 1)) begin
                        deb[i]    <= ~deb[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 8'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            first       <= 1'b0;
            en          <= 1'b0;
            a_or_m      <= 1'b1;
            rst_counter <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            first       <= first_n;
            en          <= en_n;
            a_or_m      <= dir_n;
            rst_counter <= rc_n;
            busy        <= (state_n == CLR) || (state_n == GAP);
        end
    end

    // cnt is shared: repeat timer in holds, pulse/gap length in CLR/GAP.
    always_comb begin
        held    = (state == UP_HOLD) ? deb[0] : deb[1];
        state_n = state;
        cnt_n   = cnt;
        first_n = first;
        en_n    = 1'b0;
        dir_n   = a_or_m;
        rc_n    = 1'b0;
        if (press[2] && state != CLR && state != GAP) begin
            state_n = CLR;
            cnt_n   = '0;
            rc_n    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (press[0] ^ press[1]) begin
                        state_n = press[0] ? UP_HOLD : DN_HOLD;
                        en_n    = 1'b1;
                        dir_n   = press[0];
                        cnt_n   = '0;
                        first_n = 1'b1;
                    end
                end
                UP_HOLD, DN_HOLD: begin
                    if (!held) begin
                        state_n = IDLE;
                    end else if (tick) begin
                        if (cnt == (first ? 8'(REPEAT_DELAY - 1) : 8'(REPEAT_RATE - 1))) begin
                            en_n    = 1'b1;
                            dir_n   = (state == UP_HOLD);
                            cnt_n   = '0;
                            first_n = 1'b0;
                        end else begin
                            cnt_n = cnt + 8'd1;
                        end
                    end
                end
                CLR: begin
                    if (cnt == 8'(RST_HOLD - 1)) begin
                        state_n = GAP;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 8'd1;
                        rc_n  = 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == 8'(GAP_CYCLES - 1)) state_n = IDLE;
                    else cnt_n = cnt + 8'd1;
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule
